branch_resolver: RTL and testbench
==================================

# branch_resolver

Execute-stage branch resolution unit: the producer end of the BTB update interface. It compares each resolved branch or jump against the prediction carried down from IF, and on a mispredict it issues a one-cycle redirect/flush to the PC logic. It queues training updates in a small FIFO and drains them to the BTB and predictor through a valid/ready handshake. It also keeps branch and mispredict statistics.

## Interface
- XLEN, 32, datapath width (from riscv_pkg)
- UPD_DEPTH, 4, update FIFO entries; power of two, ≥2
- CNT_WIDTH, 32, statistics counter width
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  resolved control-flow instruction present in EX
- ex_is_jump  in  1  1 = JAL/JALR, 0 = conditional branch
- ex_pc  in  XLEN  PC of the resolved instruction
- ex_pred_taken  in  1  prediction made in IF
- ex_pred_target  in  XLEN  target predicted in IF
- ex_actual_taken  in  1  resolved direction; must be 1 when ex_is_jump
- ex_actual_target  in  XLEN  resolved target
- redirect_valid  out  1  mispredict pulse; also used as pipeline flush
- redirect_pc  out  XLEN  correct fetch PC
- upd_valid  out  1  FIFO head valid
- upd_ready  in  1  BTB/predictor accepts head
- upd_pc  out  XLEN  head PC
- upd_target  out  XLEN  head actual target
- upd_taken  out  1  head actual direction
- upd_is_branch_or_jmp  out  1  head BTB write enable qualifier, equal to upd_taken
- stat_branches  out  CNT_WIDTH  accepted resolutions
- stat_mispredicts  out  CNT_WIDTH  mispredicts
- stat_dropped  out  CNT_WIDTH  updates dropped on full FIFO

## Operation
- **Accept rule.** A resolution is accepted when ex_valid=1 and redirect_valid=0. If ex_valid=1 in a cycle where redirect_valid=1, the instruction is wrong-path: it is ignored entirely, with no counters, no enqueue and no redirect.
- **Mispredict condition.** (pred_taken ≠ actual_taken) OR (pred_taken AND actual_taken AND pred_target ≠ actual_target).
- **Redirect.** On an accepted mispredict, the next cycle drives redirect_valid=1 for exactly one cycle.
  - redirect_pc = actual_target if actual_taken, else ex_pc+4.
  - The addition is modulo 2^XLEN: 0xFFFFFFFC+4 = 0.
- **Enqueue.** Every accepted resolution pushes {ex_pc, actual_target, actual_taken} into the FIFO.
- **Dequeue.** The head pops when upd_valid AND upd_ready.
  - upd_* outputs hold stable while upd_valid=1 and upd_ready=0.
  - Pops are strictly in order.
- **FIFO full.** On a push to a full FIFO with no pop in the same cycle, the new entry is discarded and stat_dropped increments. Push and pop in the same cycle on a full FIFO both succeed, and occupancy stays UPD_DEPTH.
- **FIFO empty.** upd_valid=0 and the upd_* data outputs read as don't-care. There is no bypass, so a push into an empty FIFO becomes visible on the following cycle.
- **Counters.**
  - stat_branches increments per accepted resolution.
  - stat_mispredicts increments per accepted mispredict.
  - All counters wrap at 2^CNT_WIDTH with no saturation.

## Timing
- **Reset values.** While reset_n=0, asynchronously:
  - redirect_valid=0, redirect_pc=0.
  - upd_valid=0, and all upd_* outputs are 0.
  - All counters 0; FIFO pointers and occupancy 0.
- **Reset release.** The first clk edge after deassertion may accept a resolution.
- **Reset mid-operation.** Any queued updates and any pending redirect are lost.
- **Redirect latency.** 1 cycle from the accepted ex_valid edge to the redirect_valid pulse.
- **Update latency.** At least 1 cycle from the accept edge to upd_valid, plus the queue wait.
- **Throughput.** 1 accept and 1 pop per cycle.
- **Back-to-back mispredicts.** Impossible by construction: the cycle after a mispredict is always squashed.
- **Counter update.** Counters change on the same edge that accepts the resolution.

## Structure
- **riscv_pkg additions:**
  - typedef btb_update_t {pc, target, taken}.
  - Localparam BRU_UPD_DEPTH = 4.
  - Function is_mispredict(pred_taken, pred_target, act_taken, act_target).
- **Sub-module:** sync_fifo.
  - Parameterised by type/width and depth.
  - Ports: push, pop, full, empty, and a registered head output.
  - Uses the same clk/reset_n.
- **Parent responsibilities** (branch_resolver): accept/squash logic, the redirect register, drop handling and the counters.

## Test plan
- **Correct prediction, then squash check.** Branch pc=0x100, pred taken→0x200, actual taken→0x200:
  - No redirect.
  - stat_branches=1, stat_mispredicts=0.
  - The next cycle shows upd_valid=1 with {0x100, 0x200, 1}.
- **Direction mispredict.** pc=0x100, pred not-taken, actual taken→0x180:
  - redirect_valid pulses for 1 cycle with redirect_pc=0x180.
  - ex_valid=1 held in that pulse cycle is ignored: stat_branches stays 1.
- **Not-taken mispredict with PC wrap.** pc=0xFFFFFFFC, pred taken→0x40, actual not-taken:
  - redirect_pc=0x0.
  - Queued entry has upd_taken=0 and upd_is_branch_or_jmp=0.
- **Target mispredict on JALR.** pred taken→0x300, actual taken→0x340:
  - redirect_pc=0x340, stat_mispredicts increments.
- **Backpressure and overflow.** upd_ready=0 with 6 accepted resolutions:
  - FIFO holds the first 4 in order, stat_dropped=2.
  - Raising upd_ready drains the 4 entries in 4 consecutive cycles.
  - A simultaneous push+pop while full keeps occupancy at 4 and drops nothing.
- **Async reset mid-drain.** Assert reset_n=0 between clock edges with 3 entries queued and a redirect pending:
  - Outputs go to 0 immediately, before the next edge.
  - After release, the FIFO is empty and counters read 0.

Source files
------------

// File: rtl/branch_resolver_pkg.sv
// Shared types and helpers for the EX-stage branch resolver and its BTB update path.
// Holds the datapath width, the update record layout and the mispredict rule.
package branch_resolver_pkg;

  localparam int XLEN          = 32;
  localparam int BRU_UPD_DEPTH = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic            taken;
  } btb_update_t;

  // A taken/taken pair still mispredicts when the predicted target was wrong.
  function automatic logic is_mispredict(input logic            pred_taken,
                                         input logic [XLEN-1:0] pred_target,
                                         input logic            act_taken,
                                         input logic [XLEN-1:0] act_target);
    return (pred_taken != act_taken) ||
           (pred_taken && act_taken && (pred_target != act_target));
  endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// EX-stage resolution inputs, redirect/flush outputs, BTB update handshake and statistics.
// The resolver drives through the master modport; the pipeline/BTB side uses slave.
interface branch_resolver_if
  import branch_resolver_pkg::*;
#(
  parameter int CNT_WIDTH = 32
);
  logic                 ex_valid;
  logic                 ex_is_jump;
  logic [XLEN-1:0]      ex_pc;
  logic                 ex_pred_taken;
  logic [XLEN-1:0]      ex_pred_target;
  logic                 ex_actual_taken;
  logic [XLEN-1:0]      ex_actual_target;

  logic                 redirect_valid;
  logic [XLEN-1:0]      redirect_pc;

  logic                 upd_valid;
  logic                 upd_ready;
  logic [XLEN-1:0]      upd_pc;
  logic [XLEN-1:0]      upd_target;
  logic                 upd_taken;
  logic                 upd_is_branch_or_jmp;

  logic [CNT_WIDTH-1:0] stat_branches;
  logic [CNT_WIDTH-1:0] stat_mispredicts;
  logic [CNT_WIDTH-1:0] stat_dropped;

  modport master (
    input  ex_valid, ex_is_jump, ex_pc, ex_pred_taken, ex_pred_target,
           ex_actual_taken, ex_actual_target, upd_ready,
    output redirect_valid, redirect_pc, upd_valid, upd_pc, upd_target,
           upd_taken, upd_is_branch_or_jmp,
           stat_branches, stat_mispredicts, stat_dropped
  );

  modport slave (
    output ex_valid, ex_is_jump, ex_pc, ex_pred_taken, ex_pred_target,
           ex_actual_taken, ex_actual_target, upd_ready,
    input  redirect_valid, redirect_pc, upd_valid, upd_pc, upd_target,
           upd_taken, upd_is_branch_or_jmp,
           stat_branches, stat_mispredicts, stat_dropped
  );

endinterface

// File: rtl/branch_resolver_fifo.sv
// Small synchronous FIFO with a registered head; push to a full FIFO succeeds only
// when a pop happens in the same cycle. Head is valid whenever o_empty is low.
module sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output logic o_full,
  output logic o_empty,
  output T     o_head
);
  localparam int             AW      = $clog2(DEPTH);
  localparam logic [AW-1:0]  PTR_ONE = AW'(1);
  localparam logic [AW:0]    CNT_ONE = (AW + 1)'(1);

  T              r_mem [DEPTH];
  T              r_head;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_pop_ok;
  logic w_push_ok;
  T     w_head_next;

  assign o_full    = (r_count == (AW + 1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_head;
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  always_comb begin
    // NOTE: default first so every path assigns w_head_next; otherwise a latch is inferred.
    w_head_next = r_head;
    if (w_pop_ok && (r_count > CNT_ONE))
      w_head_next = r_mem[r_rd_ptr + PTR_ONE];
    else if (w_push_ok && (o_empty || (w_pop_ok && (r_count == CNT_ONE))))
      w_head_next = i_data;
  end

  // NOTE: storage is not reset; r_count gates validity, so only control state needs reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      r_head <= w_head_next;
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push_ok && !w_pop_ok)      r_count <= r_count + CNT_ONE;
      else if (w_pop_ok && !w_push_ok) r_count <= r_count - CNT_ONE;
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolution: compares outcome to the IF prediction, issues a one-cycle
// redirect on mispredict, queues BTB training updates and keeps branch statistics.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int UPD_DEPTH = BRU_UPD_DEPTH,
  parameter int CNT_WIDTH = 32
) (
  input logic               clk,
  input logic               reset_n,
  branch_resolver_if.master bru
);
  logic                 r_redirect_valid;
  logic [XLEN-1:0]      r_redirect_pc;
  logic [CNT_WIDTH-1:0] r_branches;
  logic [CNT_WIDTH-1:0] r_mispredicts;
  logic [CNT_WIDTH-1:0] r_dropped;

  logic        w_accept;
  logic        w_mispredict;
  logic        w_pop;
  logic        w_drop;
  logic        w_full;
  logic        w_empty;
  btb_update_t w_entry;
  btb_update_t w_head;

  // The cycle after a redirect carries a wrong-path instruction; it is squashed entirely.
  assign w_accept     = bru.ex_valid && !r_redirect_valid;
  assign w_mispredict = w_accept && is_mispredict(bru.ex_pred_taken, bru.ex_pred_target,
                                                  bru.ex_actual_taken, bru.ex_actual_target);
  assign w_pop        = !w_empty && bru.upd_ready;
  assign w_drop       = w_accept && w_full && !w_pop;

  assign w_entry.pc     = bru.ex_pc;
  assign w_entry.target = bru.ex_actual_target;
  assign w_entry.taken  = bru.ex_actual_taken;

  sync_fifo #(
    .T     (btb_update_t),
    .DEPTH (UPD_DEPTH)
  ) u_upd_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_accept),
    .i_data  (w_entry),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_branches       <= '0;
      r_mispredicts    <= '0;
      r_dropped        <= '0;
    end else begin
      r_redirect_valid <= w_mispredict;
      if (w_mispredict)
        r_redirect_pc <= bru.ex_actual_taken ? bru.ex_actual_target : bru.ex_pc + XLEN'(4);
      if (w_accept)     r_branches    <= r_branches + CNT_WIDTH'(1);
      if (w_mispredict) r_mispredicts <= r_mispredicts + CNT_WIDTH'(1);
      if (w_drop)       r_dropped     <= r_dropped + CNT_WIDTH'(1);
    end
  end

  assign bru.redirect_valid       = r_redirect_valid;
  assign bru.redirect_pc          = r_redirect_pc;
  assign bru.upd_valid            = !w_empty;
  assign bru.upd_pc               = w_head.pc;
  assign bru.upd_target           = w_head.target;
  assign bru.upd_taken            = w_head.taken;
  assign bru.upd_is_branch_or_jmp = w_head.taken;
  assign bru.stat_branches        = r_branches;
  assign bru.stat_mispredicts     = r_mispredicts;
  assign bru.stat_dropped         = r_dropped;

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: directed resolutions push expected redirects and
// BTB updates into queues; a negedge monitor pops and compares whatever the DUT presents.
module tb_branch_resolver;
  import branch_resolver_pkg::*;

  logic clk;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  btb_update_t       exp_upd[$];
  logic [XLEN-1:0]   exp_redir[$];

  branch_resolver_if #(.CNT_WIDTH(32)) bru();

  branch_resolver #(.UPD_DEPTH(4), .CNT_WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bru     (bru)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every redirect pulse and every visible update head against the queues.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bru.redirect_valid) begin
        if (exp_redir.size() == 0) check("unexpected_redirect", bru.redirect_valid, 0);
        else check("redirect_pc", bru.redirect_pc, exp_redir.pop_front());
      end
      if (bru.upd_valid) begin
        if (exp_upd.size() == 0) check("unexpected_upd_valid", bru.upd_valid, 0);
        else begin
          check("upd_pc", bru.upd_pc, exp_upd[0].pc);
          check("upd_target", bru.upd_target, exp_upd[0].target);
          check("upd_taken", bru.upd_taken, exp_upd[0].taken);
          check("upd_is_branch_or_jmp", bru.upd_is_branch_or_jmp, exp_upd[0].taken);
          if (bru.upd_ready) void'(exp_upd.pop_front());
        end
      end
    end
  end

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic jmp, input logic [XLEN-1:0] pc,
                       input logic pt, input logic [XLEN-1:0] ptg,
                       input logic at, input logic [XLEN-1:0] atg,
                       input bit exp_enq, input bit exp_rd, input logic [XLEN-1:0] exp_rpc);
    btb_update_t e;
    bru.ex_valid         = 1'b1;
    bru.ex_is_jump       = jmp;
    bru.ex_pc            = pc;
    bru.ex_pred_taken    = pt;
    bru.ex_pred_target   = ptg;
    bru.ex_actual_taken  = at;
    bru.ex_actual_target = atg;
    e.pc = pc;
    e.target = atg;
    e.taken = at;
    if (exp_enq) exp_upd.push_back(e);
    if (exp_rd)  exp_redir.push_back(exp_rpc);
    @(posedge clk);
    #1;
    bru.ex_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && (exp_upd.size() != 0 || exp_redir.size() != 0); i++) idle();
    check("upd_queue_drained", 64'(exp_upd.size()), 0);
    check("redirect_queue_drained", 64'(exp_redir.size()), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_redirect_valid"}, bru.redirect_valid, 0);
    check({tag, "_redirect_pc"}, bru.redirect_pc, 0);
    check({tag, "_upd_valid"}, bru.upd_valid, 0);
    check({tag, "_upd_pc"}, bru.upd_pc, 0);
    check({tag, "_upd_target"}, bru.upd_target, 0);
    check({tag, "_upd_taken"}, bru.upd_taken, 0);
    check({tag, "_upd_bj"}, bru.upd_is_branch_or_jmp, 0);
    check({tag, "_stat_branches"}, bru.stat_branches, 0);
    check({tag, "_stat_mispredicts"}, bru.stat_mispredicts, 0);
    check({tag, "_stat_dropped"}, bru.stat_dropped, 0);
  endtask

  initial begin
    reset_n              = 1'b0;
    bru.ex_valid         = 1'b0;
    bru.ex_is_jump       = 1'b0;
    bru.ex_pc            = '0;
    bru.ex_pred_taken    = 1'b0;
    bru.ex_pred_target   = '0;
    bru.ex_actual_taken  = 1'b0;
    bru.ex_actual_target = '0;
    bru.upd_ready        = 1'b1;
    #1;
    check_all_zero("reset");
    #11;
    reset_n = 1'b1;
    idle();

    // Correct prediction: no redirect, update visible next cycle.
    issue(0, 32'h100, 1, 32'h200, 1, 32'h200, 1, 0, 0);
    check("t1_stat_branches", bru.stat_branches, 1);
    check("t1_stat_mispredicts", bru.stat_mispredicts, 0);
    check("t1_upd_valid", bru.upd_valid, 1);
    idle();

    // Direction mispredict, then a wrong-path instruction held during the pulse.
    issue(0, 32'h100, 0, 32'h0, 1, 32'h180, 1, 1, 32'h180);
    check("t2_redirect_pulse", bru.redirect_valid, 1);
    issue(0, 32'h104, 0, 32'h0, 0, 32'h0, 0, 0, 0);
    check("t2_redirect_ended", bru.redirect_valid, 0);
    check("t2_stat_branches", bru.stat_branches, 2);
    check("t2_stat_mispredicts", bru.stat_mispredicts, 1);
    idle();

    // Not-taken mispredict at the top of the address space: fall-through wraps to 0.
    issue(0, 32'hFFFF_FFFC, 1, 32'h40, 0, 32'h40, 1, 1, 32'h0);
    idle();

    // JALR target mispredict.
    issue(1, 32'h400, 1, 32'h300, 1, 32'h340, 1, 1, 32'h340);
    check("t4_stat_mispredicts", bru.stat_mispredicts, 3);
    idle();
    wait_drain();

    // Backpressure: 6 accepts into a 4-entry FIFO, last two dropped.
    bru.upd_ready = 1'b0;
    for (int i = 0; i < 6; i++)
      issue(0, 32'h1000 + 32'(4 * i), 1, 32'h2000 + 32'(4 * i), 1, 32'h2000 + 32'(4 * i),
            i < 4, 0, 0);
    check("t5_stat_dropped", bru.stat_dropped, 2);
    check("t5_stat_branches", bru.stat_branches, 10);
    idle();
    // Push and pop together while full: nothing dropped, occupancy stays 4.
    bru.upd_ready = 1'b1;
    issue(0, 32'h1100, 1, 32'h2100, 1, 32'h2100, 1, 0, 0);
    check("t5_full_pushpop_dropped", bru.stat_dropped, 2);
    check("t5_stat_branches_after", bru.stat_branches, 11);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_drain_consecutive", bru.upd_valid, 1);
    end
    @(negedge clk);
    check("t5_drain_empty", bru.upd_valid, 0);
    wait_drain();

    // Async reset with 3 queued updates and a redirect pending.
    bru.upd_ready = 1'b0;
    idle();
    issue(0, 32'h500, 1, 32'h600, 1, 32'h600, 1, 0, 0);
    issue(0, 32'h504, 1, 32'h700, 1, 32'h700, 1, 0, 0);
    issue(0, 32'h508, 0, 32'h0, 1, 32'h800, 1, 1, 32'h800);
    check("t6_pre_reset_redirect", bru.redirect_valid, 1);
    check("t6_pre_reset_upd_valid", bru.upd_valid, 1);
    #1;
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_upd.delete();
    exp_redir.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle();
    check_all_zero("post_reset");
    bru.upd_ready = 1'b1;
    issue(0, 32'h900, 1, 32'hA00, 1, 32'hA00, 1, 0, 0);
    check("t6_stat_branches_after_reset", bru.stat_branches, 1);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
